// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for elastic pipeline stages
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

   // Clear wins over increment so software can zero the count mid-stall.
   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && (value != MAX_VALUE)) begin
         value <= value + ONE;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid pipeline register with flush and stall counter
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                       PAYLOAD_WIDTH = 256,
   parameter logic [PAYLOAD_WIDTH-1:0] NOP_PAYLOAD   = '0,
   parameter int                       CNT_WIDTH     = 16
) (
   input  logic                     cpu_clk,
   input  logic                     cpu_rst_n,
   input  logic                     flush,
   input  logic                     up_valid,
   output logic                     up_ready,
   input  logic [PAYLOAD_WIDTH-1:0] up_payload,
   output logic                     dn_valid,
   input  logic                     dn_ready,
   output logic [PAYLOAD_WIDTH-1:0] dn_payload,
   output logic [1:0]               occupancy,
   output logic [CNT_WIDTH-1:0]     stall_cnt,
   input  logic                     stall_cnt_clr
);

   stage_state_t             state_q, state_d;
   logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
   logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
   logic                     beat_in, beat_out;

   // Handshake outputs come from the state register only; no path from dn_ready.
   assign up_ready   = (state_q != FULL);
   assign dn_valid   = (state_q != EMPTY);
   assign dn_payload = main_q;
   assign beat_in    = up_valid & up_ready;
   assign beat_out   = dn_valid & dn_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (beat_in) begin
               state_d = BUSY;
               main_d  = up_payload;
            end
         end
         BUSY: begin
            if (beat_in && beat_out) begin
               main_d = up_payload;
            end else if (beat_in) begin
               state_d = FULL;
               skid_d  = up_payload;
            end else if (beat_out) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (beat_out) begin
               state_d = BUSY;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      // Flush overrides everything: incoming beat is dropped, held beats replaced by bubbles.
      if (flush) begin
         state_d = EMPTY;
         main_d  = NOP_PAYLOAD;
         skid_d  = NOP_PAYLOAD;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         state_q <= EMPTY;
         main_q  <= NOP_PAYLOAD;
         skid_q  <= NOP_PAYLOAD;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      occupancy = OCC_EMPTY;
      case (state_q)
         EMPTY:   occupancy = OCC_EMPTY;
         BUSY:    occupancy = OCC_ONE;
         FULL:    occupancy = OCC_TWO;
         default: occupancy = OCC_EMPTY;
      endcase
   end

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .cpu_clk   (cpu_clk),
      .cpu_rst_n (cpu_rst_n),
      .inc       (dn_valid & ~dn_ready),
      .clr       (stall_cnt_clr),
      .value     (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage
module tb_pipe_skid_stage;

   localparam int          PW  = 32;
   localparam int          CW  = 4;
   localparam logic [31:0] NOP = 32'hDEAD_BEEF;
   localparam int          CNT_MAX = 15;

   logic          cpu_clk = 1'b0;
   logic          cpu_rst_n;
   logic          flush;
   logic          up_valid;
   logic          up_ready;
   logic [PW-1:0] up_payload;
   logic          dn_valid;
   logic          dn_ready;
   logic [PW-1:0] dn_payload;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;
   logic          stall_cnt_clr;

   int checks = 0;
   int failures = 0;
   int delivered = 0;

   logic [PW-1:0] exp_q[$];
   int            exp_stall = 0;
   logic          nop_exp = 1'b1;
   logic          acc_ok = 1'b0;

   pipe_skid_stage #(
      .PAYLOAD_WIDTH (PW),
      .NOP_PAYLOAD   (NOP),
      .CNT_WIDTH     (CW)
   ) dut (
      .cpu_clk       (cpu_clk),
      .cpu_rst_n     (cpu_rst_n),
      .flush         (flush),
      .up_valid      (up_valid),
      .up_ready      (up_ready),
      .up_payload    (up_payload),
      .dn_valid      (dn_valid),
      .dn_ready      (dn_ready),
      .dn_payload    (dn_payload),
      .occupancy     (occupancy),
      .stall_cnt     (stall_cnt),
      .stall_cnt_clr (stall_cnt_clr)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle and compared against the queue model.
   always @(negedge cpu_clk) begin
      int size;
      size = exp_q.size();
      if (!cpu_rst_n) begin
         exp_q.delete();
         exp_stall = 0;
         nop_exp   = 1'b1;
         acc_ok    = 1'b0;
      end else begin
         chk("occupancy", 64'(occupancy), 64'(size));
         chk("up_ready", 64'(up_ready), 64'(size < 2));
         chk("dn_valid", 64'(dn_valid), 64'(size > 0));
         chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
         if (nop_exp && size == 0)
            chk("nop_payload", 64'(dn_payload), 64'(NOP));
         acc_ok = (size < 2);
         if (dn_valid && dn_ready) begin
            if (size == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got %0h expected none at %0t", dn_payload, $time);
            end else begin
               chk("dn_payload", 64'(dn_payload), 64'(exp_q.pop_front()));
               delivered++;
            end
         end
         if (stall_cnt_clr)
            exp_stall = 0;
         else if (size > 0 && !dn_ready && exp_stall < CNT_MAX)
            exp_stall++;
         if (flush) begin
            exp_q.delete();
            nop_exp = 1'b1;
         end
      end
   end

   // Drive one cycle; the expected beat is queued once the model says it is accepted.
   task automatic step(input logic uv, input logic [PW-1:0] pl, input logic dr,
                       input logic fl, input logic clr);
      up_valid      = uv;
      up_payload    = pl;
      dn_ready      = dr;
      flush         = fl;
      stall_cnt_clr = clr;
      @(negedge cpu_clk);
      #1;
      if (cpu_rst_n && !fl && uv && acc_ok) begin
         exp_q.push_back(pl);
         nop_exp = 1'b0;
      end
      @(posedge cpu_clk);
      #1;
   endtask

   initial begin
      cpu_rst_n     = 1'b0;
      up_valid      = 1'b1;
      up_payload    = 32'hA5;
      dn_ready      = 1'b1;
      flush         = 1'b0;
      stall_cnt_clr = 1'b0;
      step(1, 32'hA5, 1, 0, 0);
      step(1, 32'hA5, 1, 0, 0);
      cpu_rst_n = 1'b1;
      chk("reset_dn_valid", 64'(dn_valid), 64'd0);
      chk("reset_up_ready", 64'(up_ready), 64'd1);
      chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      for (int i = 1; i <= 8; i++) step(1, PW'(i), 1, 0, 0);
      repeat (3) step(0, 32'h0, 1, 0, 0);

      step(1, 32'h10, 0, 0, 0);
      step(1, 32'h11, 0, 0, 0);
      chk("skid_occupancy_two", 64'(occupancy), 64'd2);
      chk("skid_up_ready_low", 64'(up_ready), 64'd0);
      step(1, 32'h12, 0, 0, 0);
      step(1, 32'h12, 1, 0, 0);
      step(1, 32'h12, 1, 0, 0);
      repeat (3) step(0, 32'h0, 1, 0, 0);

      step(1, 32'h20, 0, 0, 0);
      step(1, 32'h21, 0, 0, 0);
      step(1, 32'h22, 0, 1, 0);
      chk("flush_dn_valid", 64'(dn_valid), 64'd0);
      chk("flush_occupancy", 64'(occupancy), 64'd0);
      chk("flush_payload", 64'(dn_payload), 64'(NOP));
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      step(1, 32'h30, 0, 0, 0);
      repeat (20) step(0, 32'h0, 0, 0, 0);
      chk("stall_saturated", 64'(stall_cnt), 64'(CNT_MAX));
      step(0, 32'h0, 0, 0, 1);
      chk("stall_cleared", 64'(stall_cnt), 64'd0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      for (int i = 0; i < 10000; i++) begin
         logic uv, dr, fl, clr;
         uv  = ($urandom % 4) != 0;
         dr  = ($urandom % 3) != 0;
         fl  = ($urandom % 64) == 0;
         clr = ($urandom % 200) == 0;
         cpu_rst_n = ($urandom % 800) != 0;
         step(uv, PW'($urandom), dr, fl, clr);
      end
      cpu_rst_n = 1'b1;
      repeat (4) step(0, 32'h0, 1, 0, 0);
      chk("drained", 64'(exp_q.size()), 64'd0);
      chk("traffic_seen", 64'(delivered > 1000), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline register that generalises the fixed ID/EX latch into a reusable stage for any inter-stage boundary of the CPU core. It carries an opaque payload of configurable width under a valid/ready handshake. A two-entry skid buffer lets the upstream ready be decoded from registered state only, so a downstream stall never forms a combinational ready path back through the pipeline. It also supports synchronous flush with a configurable bubble payload and a saturating stall-cycle performance counter.

## Interface
- PAYLOAD_WIDTH, 256, bit width of the carried stage payload (PC, instruction, control, operands packed by the instantiator)
- NOP_PAYLOAD, all zeros, payload value loaded into both entries on reset and flush
- CNT_WIDTH, 16, width of the stall performance counter
- cpu_clk  input  1  single clock; all state updates on rising edge
- cpu_rst_n  input  1  reset, synchronous, active-low
- flush  input  1  discard all held and incoming beats this cycle
- up_valid  input  1  upstream beat offered
- up_ready  output  1  stage can accept a beat; decoded from state register only
- up_payload  input  PAYLOAD_WIDTH  upstream beat data
- dn_valid  output  1  beat presented downstream
- dn_ready  input  1  downstream accepts
- dn_payload  output  PAYLOAD_WIDTH  main-entry data
- occupancy  output  2  beats held: 0, 1 or 2
- stall_cnt  output  CNT_WIDTH  cycles with dn_valid=1 and dn_ready=0; saturating
- stall_cnt_clr  input  1  synchronous clear of stall_cnt

## Operation
- Storage: main entry drives dn_payload; skid entry holds the overflow beat.
- States: EMPTY (occupancy 0), BUSY (main full), FULL (main and skid full).
- Decode: up_ready = (state != FULL); dn_valid = (state != EMPTY).
- Define in = up_valid & up_ready and out = dn_valid & dn_ready.
- EMPTY: in -> BUSY, main <= up_payload.
- BUSY, in and out -> BUSY, main <= up_payload.
- BUSY, in only -> FULL, skid <= up_payload.
- BUSY, out only -> EMPTY.
- BUSY, neither -> hold.
- FULL: in is impossible. out -> BUSY, main <= skid. Otherwise hold.
- Flush has priority over every transition. It forces next state EMPTY and loads main and skid with NOP_PAYLOAD. A beat handshaken in the flush cycle is dropped. A beat consumed downstream in the flush cycle counts as delivered.
- stall_cnt increments when dn_valid & !dn_ready and is not saturated. It holds at 2^CNT_WIDTH-1. stall_cnt_clr has priority over increment. Flush does not clear it.
- Ordering is strictly FIFO. No beat is duplicated or lost except under flush.

## Timing
- Reset (cpu_rst_n=0 at an edge) sets: state EMPTY, main = skid = NOP_PAYLOAD, stall_cnt = 0. Outputs after that edge: dn_valid 0, up_ready 1, occupancy 0, dn_payload NOP_PAYLOAD.
- Beats offered while reset is low are dropped. Reset mid-transfer discards both entries.
- Latency is 1 cycle: a beat accepted at edge N is on dn_payload with dn_valid=1 after edge N.
- Throughput is 1 beat/cycle sustained with dn_ready held high.
- up_ready falls one cycle after the first stalled accept (BUSY->FULL). It rises one cycle after the downstream drains FULL.
- After a flush edge: dn_valid=0 and up_ready=1 in the next cycle.

## Structure
- Shared package pipe_pkg:
  - stage_state_t enum (EMPTY, BUSY, FULL)
  - occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2
- The saturating counter is a natural sub-module, sat_counter (parameter WIDTH; ports inc, clr, value). It is reused by other perf counters.
- The datapath is two PAYLOAD_WIDTH registers with load muxes. No further hierarchy.

## Test plan
- Reset: hold cpu_rst_n=0 for 2 cycles with up_valid=1 and up_payload=0xA5 -> dn_valid=0, up_ready=1, occupancy=0, stall_cnt=0, and no beat emerges afterwards.
- Streaming: dn_ready=1, send payloads 1..8 on consecutive cycles -> dn_payload 1..8 on consecutive cycles, 1-cycle latency, up_ready never low.
- Stall/skid: send 0x10, 0x11, 0x12 back-to-back with dn_ready=0 -> occupancy 1 then 2, up_ready=0 after the second accept, 0x12 held upstream. Release dn_ready -> 0x10, 0x11, 0x12 delivered in order with no loss.
- Flush while FULL: entries 0x20 and 0x21, assert flush with up_valid=1 and payload 0x22 -> next cycle dn_valid=0, occupancy=0, dn_payload=NOP_PAYLOAD, and 0x22 never delivered.
- Counter: CNT_WIDTH=4, hold dn_valid=1 and dn_ready=0 for 20 cycles -> stall_cnt saturates at 15. Pulse stall_cnt_clr together with a stall -> stall_cnt reads 0.
- Random: random up_valid and dn_ready for 10k cycles with occasional flush -> scoreboard shows an in-order match, drops only at flushes, and up_ready=0 exactly when occupancy=2.
